// File: rtl/ac_pkg.sv
// rtl/ac_pkg.sv - shared constants and state type for the product accumulator
package ac_pkg;

    localparam int PROD_W    = 16;
    localparam int ACC_W_DEF = 24;
    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } acc_state_t;

endpackage

// File: rtl/ac_prod_acc_if.sv
// rtl/ac_prod_acc_if.sv - product beat input and frame result handshake bundle
interface ac_prod_acc_if
    import ac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
);

    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [CNT_W-1:0]  out_count;
    logic              out_sat;

    modport master (
        output in_valid, in_prod, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_sat
    );

    modport slave (
        input  in_valid, in_prod, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_sat
    );

endinterface

// File: rtl/ac_sat_add.sv
// rtl/ac_sat_add.sv - unsigned saturating add of a 16-bit product onto a W-bit sum
module ac_sat_add
    import ac_pkg::*;
#(
    parameter int W = ACC_W_DEF
) (
    input  logic [W-1:0]      a,
    input  logic [PROD_W-1:0] b,
    output logic [W-1:0]      sum,
    output logic              ovf
);

    logic [W:0] full;

    assign full = {1'b0, a} + {{(W + 1 - PROD_W){1'b0}}, b};
    assign ovf  = full[W];
    assign sum  = full[W] ? {W{1'b1}} : full[W-1:0];

endmodule

// File: rtl/ac_prod_acc.sv
// rtl/ac_prod_acc.sv - saturating frame accumulator for approximate-multiplier products
module ac_prod_acc
    import ac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    ac_prod_acc_if.slave bus
);

    acc_state_t       state;
    acc_state_t       state_nxt;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             sat;
    logic [ACC_W-1:0] sum_nxt;
    logic             ovf;
    logic [CNT_W-1:0] cnt_inc;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [ACC_W-1:0] out_sum_q;
    logic [CNT_W-1:0] out_count_q;
    logic             out_sat_q;
    logic             accept;
    logic             load_beat;
    logic             load_out;
    logic             release_out;

    ac_sat_add #(.W(ACC_W)) u_sat_add (
        .a   (acc),
        .b   (bus.in_prod),
        .sum (sum_nxt),
        .ovf (ovf)
    );

    assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + {{(CNT_W - 1){1'b0}}, 1'b1};

    // in_ready is registered from the next state so it is low through reset
    // and rises only the cycle after a result handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            in_ready_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt != HOLD);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, ACC: begin
                if (accept) begin
                    state_nxt = bus.in_last ? HOLD : ACC;
                end
            end
            HOLD: begin
                if (release_out) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        accept      = 1'b0;
        load_beat   = 1'b0;
        load_out    = 1'b0;
        release_out = 1'b0;
        case (state)
            IDLE, ACC: begin
                accept    = bus.in_valid & in_ready_q;
                load_beat = accept & ~bus.in_last;
                load_out  = accept & bus.in_last;
            end
            HOLD: begin
                release_out = out_valid_q & bus.out_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc         <= '0;
            cnt         <= '0;
            sat         <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            if (load_beat) begin
                acc <= sum_nxt;
                cnt <= cnt_inc;
                sat <= sat | ovf;
            end
            if (load_out) begin
                out_valid_q <= 1'b1;
                out_sum_q   <= sum_nxt;
                out_count_q <= cnt_inc;
                out_sat_q   <= sat | ovf;
            end
            // Result fields stay as the last frame's values after handshake.
            if (release_out) begin
                out_valid_q <= 1'b0;
                acc         <= '0;
                cnt         <= '0;
                sat         <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_count = out_count_q;
    assign bus.out_sat   = out_sat_q;

endmodule

// File: tb/tb_ac_prod_acc.sv
// tb/tb_ac_prod_acc.sv - directed bench driving three width variants with shared stimulus
module tb_ac_prod_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_prod;
    logic        in_last;
    logic        out_ready;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    // a: default widths, b: 16-bit sum, c: 2-bit count
    ac_prod_acc_if #(.ACC_W(24), .CNT_W(8)) ia ();
    ac_prod_acc_if #(.ACC_W(16), .CNT_W(8)) ib ();
    ac_prod_acc_if #(.ACC_W(24), .CNT_W(2)) ic ();

    assign ia.in_valid = in_valid;   assign ia.in_prod = in_prod;
    assign ia.in_last  = in_last;    assign ia.out_ready = out_ready;
    assign ib.in_valid = in_valid;   assign ib.in_prod = in_prod;
    assign ib.in_last  = in_last;    assign ib.out_ready = out_ready;
    assign ic.in_valid = in_valid;   assign ic.in_prod = in_prod;
    assign ic.in_last  = in_last;    assign ic.out_ready = out_ready;

    ac_prod_acc #(.ACC_W(24), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
    ac_prod_acc #(.ACC_W(16), .CNT_W(8)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));
    ac_prod_acc #(.ACC_W(24), .CNT_W(2)) dut_c (.clk(clk), .rst(rst), .bus(ic.slave));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] p, input logic l);
        in_valid = 1'b1;
        in_prod  = p;
        in_last  = l;
        step();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic chk_out(input string tag,
                           input logic v, input logic [31:0] s, input logic [31:0] c, input logic st,
                           input logic ev, input logic [31:0] es, input logic [31:0] ec, input logic est);
        check({tag, ".valid"}, {31'd0, v}, {31'd0, ev});
        check({tag, ".sum"},   s,  es);
        check({tag, ".count"}, c,  ec);
        check({tag, ".sat"},   {31'd0, st}, {31'd0, est});
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_prod   = 16'd0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // reset held two cycles, then released
        step();
        step();
        check("rst.ready_a", {31'd0, ia.in_ready}, 32'd0);
        rst = 1'b0;
        step();
        check("idle.ready_a", {31'd0, ia.in_ready}, 32'd1);
        check("idle.ready_b", {31'd0, ib.in_ready}, 32'd1);
        check("idle.ready_c", {31'd0, ic.in_ready}, 32'd1);
        chk_out("idle_a", ia.out_valid, 32'(ia.out_sum), 32'(ia.out_count), ia.out_sat, 1'b0, 32'd0, 32'd0, 1'b0);

        // three-beat frame, consumer always ready
        out_ready = 1'b1;
        beat(16'd100, 1'b0);
        beat(16'd200, 1'b0);
        beat(16'd300, 1'b1);
        chk_out("f3_a", ia.out_valid, 32'(ia.out_sum), 32'(ia.out_count), ia.out_sat, 1'b1, 32'd600, 32'd3, 1'b0);
        chk_out("f3_c", ic.out_valid, 32'(ic.out_sum), 32'(ic.out_count), ic.out_sat, 1'b1, 32'd600, 32'd3, 1'b0);
        check("f3.ready_low", {31'd0, ia.in_ready}, 32'd0);
        in_valid = 1'b0;
        step();
        check("f3.ready_back", {31'd0, ia.in_ready}, 32'd1);
        chk_out("f3_after_a", ia.out_valid, 32'(ia.out_sum), 32'(ia.out_count), ia.out_sat, 1'b0, 32'd600, 32'd3, 1'b0);

        // saturation on the 16-bit variant, plain sum on the 24-bit one
        beat(16'hFFFF, 1'b0);
        beat(16'h0001, 1'b1);
        chk_out("sat_b", ib.out_valid, 32'(ib.out_sum), 32'(ib.out_count), ib.out_sat, 1'b1, 32'hFFFF, 32'd2, 1'b1);
        chk_out("sat_a", ia.out_valid, 32'(ia.out_sum), 32'(ia.out_count), ia.out_sat, 1'b1, 32'h10000, 32'd2, 1'b0);
        in_valid = 1'b0;
        step();

        // backpressure: result held, no beats accepted
        out_ready = 1'b0;
        beat(16'h1234, 1'b1);
        chk_out("bp_a", ia.out_valid, 32'(ia.out_sum), 32'(ia.out_count), ia.out_sat, 1'b1, 32'h1234, 32'd1, 1'b0);
        in_prod = 16'h5555;
        in_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp.hold_sum", 32'(ia.out_sum), 32'h1234);
            check("bp.hold_valid", {31'd0, ia.out_valid}, 32'd1);
            check("bp.ready_low", {31'd0, ia.in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        step();
        check("bp.released", {31'd0, ia.out_valid}, 32'd0);
        check("bp.ready_back", {31'd0, ia.in_ready}, 32'd1);
        beat(16'h0010, 1'b1);
        chk_out("bp_next_a", ia.out_valid, 32'(ia.out_sum), 32'(ia.out_count), ia.out_sat, 1'b1, 32'h10, 32'd1, 1'b0);
        chk_out("bp_next_b", ib.out_valid, 32'(ib.out_sum), 32'(ib.out_count), ib.out_sat, 1'b1, 32'h10, 32'd1, 1'b0);
        in_valid = 1'b0;
        step();

        // zero-valued beats are still counted
        beat(16'd0, 1'b0);
        beat(16'd0, 1'b1);
        chk_out("zero_a", ia.out_valid, 32'(ia.out_sum), 32'(ia.out_count), ia.out_sat, 1'b1, 32'd0, 32'd2, 1'b0);
        in_valid = 1'b0;
        step();

        // count saturation on the 2-bit variant, with an idle gap mid-frame
        beat(16'd1, 1'b0);
        beat(16'd1, 1'b0);
        in_valid = 1'b0;
        step();
        step();
        check("gap.no_out", {31'd0, ia.out_valid}, 32'd0);
        beat(16'd1, 1'b0);
        beat(16'd1, 1'b0);
        beat(16'd1, 1'b1);
        chk_out("cnt_c", ic.out_valid, 32'(ic.out_sum), 32'(ic.out_count), ic.out_sat, 1'b1, 32'd5, 32'd3, 1'b0);
        chk_out("cnt_a", ia.out_valid, 32'(ia.out_sum), 32'(ia.out_count), ia.out_sat, 1'b1, 32'd5, 32'd5, 1'b0);
        in_valid = 1'b0;
        step();

        // reset mid-frame discards the partial frame
        beat(16'd9, 1'b0);
        beat(16'd9, 1'b0);
        in_valid = 1'b0;
        rst      = 1'b1;
        step();
        check("mrst.ready_low", {31'd0, ia.in_ready}, 32'd0);
        rst = 1'b0;
        step();
        chk_out("mrst_a", ia.out_valid, 32'(ia.out_sum), 32'(ia.out_count), ia.out_sat, 1'b0, 32'd0, 32'd0, 1'b0);
        beat(16'd7, 1'b1);
        chk_out("mrst_next_a", ia.out_valid, 32'(ia.out_sum), 32'(ia.out_count), ia.out_sat, 1'b1, 32'd7, 32'd1, 1'b0);
        chk_out("mrst_next_c", ic.out_valid, 32'(ic.out_sum), 32'(ic.out_count), ic.out_sat, 1'b1, 32'd7, 32'd1, 1'b0);
        in_valid = 1'b0;
        step();
        check("mrst.released", {31'd0, ia.out_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ac_prod_acc.md
Name: ac_prod_acc

Overview:
- Streaming accumulator directly downstream of the 8x8 approximate multiplier (the 1222-configuration ac_1222 block).
- Consumes the 16-bit unsigned prod8 beats through a valid/ready handshake. Sums one frame of products (dot-product style) with saturation.
- Presents the frame sum, beat count and saturation flag on a held output handshake.
- Used to measure accumulated approximation error over vector workloads.

Parameters:
- ACC_W, 24, accumulator/output sum width in bits; legal range 16..32.
- CNT_W, 8, beat-counter width; the count saturates at 2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  product beat valid
- in_ready  output  1  block can accept a beat
- in_prod  input  16  unsigned product from the multiplier (prod8)
- in_last  input  1  accepted beat is the final beat of the frame
- out_valid  output  1  frame result valid
- out_ready  input  1  consumer accepts the result
- out_sum  output  ACC_W  saturated unsigned frame sum
- out_count  output  CNT_W  beats in the frame (saturating)
- out_sat  output  1  sum saturated at least once in the frame

Behaviour:
- Reset (rst=1 at a clk edge) has priority over everything:
  - State becomes IDLE; accumulator, counter and sat flag are cleared.
  - out_valid=0, out_sum=0, out_count=0, out_sat=0.
  - in_ready=0 during the reset cycle and 1 from the first cycle after reset deasserts.
  - Reset mid-frame or while a result is held discards all data; no output is produced.
- States:
  - IDLE: no beats accepted in the current frame.
  - ACC: at least one beat accepted, no in_last yet.
  - HOLD: result presented.
- in_ready is 1 in IDLE and ACC, and 0 in HOLD. Accept = in_valid & in_ready.
- Accept without in_last:
  - acc <= satadd(acc, zero-extended in_prod).
  - cnt <= min(cnt+1, 2^CNT_W-1).
  - sat <= sat | overflow.
  - Next state is ACC.
- Accept with in_last (from IDLE or ACC):
  - out_sum <= satadd(acc, in_prod); out_count <= min(cnt+1, max); out_sat <= sat | overflow.
  - out_valid <= 1; next state is HOLD.
  - Latency: out_valid is high in the cycle after the last accepted beat.
- satadd: compute the (ACC_W+1)-bit sum. If the MSB is set, the result is 2^ACC_W-1 and overflow=1. Once saturated, the accumulator stays at the maximum for the rest of the frame.
- HOLD:
  - out_sum, out_count and out_sat stay stable until out_valid & out_ready.
  - On that handshake: out_valid <= 0; acc, cnt and sat clear; next state is IDLE. in_ready is 1 in the following cycle, not the same cycle.
  - out_ready while out_valid=0 is ignored.
- in_valid=0 in ACC: hold state, no change.
- Single-beat frame (in_last on the first beat from IDLE): out_sum=in_prod, out_count=1.
- in_prod=0 beats are counted normally.
- out_* values after the handshake: out_valid drops; out_sum, out_count and out_sat hold their last values until the next frame completes.
- No combinational path from in_* to out_*. in_ready depends on state only.

Decomposition:
- Shared package ac_pkg:
  - PROD_W=16 constant, matching the 8x8 multiplier output.
  - ACC_W and CNT_W defaults.
  - State enum {IDLE, ACC, HOLD} as acc_state_t.
- One sub-module: ac_sat_add. Parameter W; inputs a[W-1:0] and b[15:0]; outputs sum[W-1:0] and ovf. Purely combinational; shared with future error-accumulation blocks.
- Top level holds the FSM, registers and handshake.

Test Plan:
- Reset then idle:
  - Hold rst 2 cycles, then release.
  - Required: out_valid=0, out_sum=0, out_count=0, out_sat=0, and in_ready=1 one cycle after release.
- Three-beat frame, out_ready=1 throughout:
  - Beats 100, 200, 300 with last on 300.
  - Required: next cycle out_valid=1, out_sum=600, out_count=3, out_sat=0.
  - Required: in_ready=0 for exactly one cycle, then 1.
- Saturation with ACC_W=16:
  - Beats 0xFFFF, 0x0001 with last on 0x0001.
  - Required: out_sum=0xFFFF, out_count=2, out_sat=1.
- Backpressure:
  - Single-beat frame 0x1234, then out_ready=0 for 5 cycles while in_valid=1 with other data.
  - Required: out_sum stays 0x1234, in_ready stays 0 and no beat is accepted.
  - Then out_ready=1. Required: handshake, and the next frame starts from acc=0.
- Counter saturation with CNT_W=2:
  - Five beats of value 1, last on the fifth.
  - Required: out_count=3, out_sum=5.
- Reset mid-frame:
  - Accept 2 beats, assert rst, then send a single-beat frame of 7.
  - Required: no output for the aborted frame; the next result is out_sum=7, out_count=1.
